// File: rtl/way_hit_select_if.sv
`default_nettype none
// ============================================================================
//  Module      : way_hit_select_if
//  Description : Lookup request/result bundle for the 4-way hit selector.
//                The master drives the request side and observes results;
//                the slave (the selector) does the reverse.
//  Revision    : 1.0  initial release
// ============================================================================
interface way_hit_select_if #(
   parameter int TAG_BITS  = 18,
   parameter int LINE_BITS = 32
);
   // request side
   logic                   i_valid;
   logic [TAG_BITS-1:0]    i_tag;
   logic [4*TAG_BITS-1:0]  i_way_tags;
   logic [3:0]             i_way_valid;
   logic [4*LINE_BITS-1:0] i_way_lines;
   // result side
   logic                   o_valid;
   logic                   o_hit;
   logic [1:0]             o_hit_way;
   logic [3:0]             o_hit_vec;
   logic [LINE_BITS-1:0]   o_line;
   logic                   o_multi_hit;

   modport master (
      output i_valid, i_tag, i_way_tags, i_way_valid, i_way_lines,
      input  o_valid, o_hit, o_hit_way, o_hit_vec, o_line, o_multi_hit
   );

   modport slave (
      input  i_valid, i_tag, i_way_tags, i_way_valid, i_way_lines,
      output o_valid, o_hit, o_hit_way, o_hit_vec, o_line, o_multi_hit
   );
endinterface
`default_nettype wire

// File: rtl/way_hit_select.sv
`default_nettype none
// ============================================================================
//  Module      : way_hit_select
//  Description : 4-way set-associative tag compare with lowest-index priority
//                select and one-cycle registered result. Result registers
//                hold their contents while no lookup is presented.
//                Optional macro WAY_HIT_SELECT_MULTI_HIT_EN enables the
//                multiple-match flag; otherwise o_multi_hit is tied to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module way_hit_select #(
   parameter int TAG_BITS  = 18,
   parameter int LINE_BITS = 32
) (
   input  wire logic       clk,
   input  wire logic       rst,     // asynchronous, active-low
   way_hit_select_if.slave bus
);

   logic [3:0]           sel;
   logic                 any_hit;
   logic [1:0]           sel_idx;
   logic [LINE_BITS-1:0] sel_line;

   logic                 valid_d,   valid_q;
   logic                 hit_d,     hit_q;
   logic [1:0]           hit_way_d, hit_way_q;
   logic [3:0]           hit_vec_d, hit_vec_q;
   logic [LINE_BITS-1:0] line_d,    line_q;

   // Full-width tag compare per way, gated by the way's valid bit.
   always_comb begin
      sel = '0;
      for (int w = 0; w < 4; w++) begin
         sel[w] = bus.i_way_valid[w] &&
                  (bus.i_way_tags[w*TAG_BITS +: TAG_BITS] == bus.i_tag);
      end
   end

   // Priority encode (way 0 wins) and 4:1 line mux on the chosen index.
   always_comb begin
      any_hit = |sel;
      sel_idx = 2'd0;
      for (int w = 3; w >= 0; w--) begin
         if (sel[w]) sel_idx = w[1:0];
      end
      sel_line = '0;
      if (any_hit) begin
         case (sel_idx)
            2'd0:    sel_line = bus.i_way_lines[0*LINE_BITS +: LINE_BITS];
            2'd1:    sel_line = bus.i_way_lines[1*LINE_BITS +: LINE_BITS];
            2'd2:    sel_line = bus.i_way_lines[2*LINE_BITS +: LINE_BITS];
            default: sel_line = bus.i_way_lines[3*LINE_BITS +: LINE_BITS];
         endcase
      end
   end

   // Next-state: capture a new result on a lookup, otherwise hold.
   always_comb begin
      valid_d   = bus.i_valid;
      hit_d     = hit_q;
      hit_way_d = hit_way_q;
      hit_vec_d = hit_vec_q;
      line_d    = line_q;
      if (bus.i_valid) begin
         hit_d     = any_hit;
         hit_way_d = sel_idx;
         hit_vec_d = sel;
         line_d    = sel_line;
      end
   end

   // Result registers; reset clears them immediately, independent of clk.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q   <= 1'b0;
         hit_q     <= 1'b0;
         hit_way_q <= 2'd0;
         hit_vec_q <= 4'd0;
         line_q    <= '0;
      end else begin
         valid_q   <= valid_d;
         hit_q     <= hit_d;
         hit_way_q <= hit_way_d;
         hit_vec_q <= hit_vec_d;
         line_q    <= line_d;
      end
   end

`ifdef WAY_HIT_SELECT_MULTI_HIT_EN
   logic multi_hit_d, multi_hit_q;

   // Two or more matches: clearing the lowest set bit still leaves one.
   always_comb begin
      multi_hit_d = multi_hit_q;
      if (bus.i_valid) multi_hit_d = ((sel & (sel - 4'd1)) != 4'd0);
   end

   // Multi-hit flag register, same reset and hold behaviour as the rest.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) multi_hit_q <= 1'b0;
      else      multi_hit_q <= multi_hit_d;
   end

   assign bus.o_multi_hit = multi_hit_q;
`else
   assign bus.o_multi_hit = 1'b0;
`endif

   assign bus.o_valid   = valid_q;
   assign bus.o_hit     = hit_q;
   assign bus.o_hit_way = hit_way_q;
   assign bus.o_hit_vec = hit_vec_q;
   assign bus.o_line    = line_q;

endmodule
`default_nettype wire

// File: tb/tb_way_hit_select.sv
`default_nettype none
// ============================================================================
//  Module      : tb_way_hit_select
//  Description : Self-checking bench for way_hit_select: directed cases plus
//                randomized lookups compared against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_way_hit_select;

   localparam int TB = 18;
   localparam int LB = 32;
`ifdef WAY_HIT_SELECT_MULTI_HIT_EN
   localparam bit MULTI_EN = 1'b1;
`else
   localparam bit MULTI_EN = 1'b0;
`endif

   logic clk;
   logic rst;

   way_hit_select_if #(.TAG_BITS(TB), .LINE_BITS(LB)) bus ();

   way_hit_select #(.TAG_BITS(TB), .LINE_BITS(LB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // stimulus held as plain arrays, packed onto the bus before each edge
   logic          m_valid;
   logic [TB-1:0] m_tag;
   logic [TB-1:0] m_tags  [4];
   logic [LB-1:0] m_lines [4];
   logic [3:0]    m_vmask;

   // expected outputs
   logic          e_valid, e_hit, e_multi;
   logic [1:0]    e_way;
   logic [3:0]    e_vec;
   logic [LB-1:0] e_line;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".valid"}, 64'(bus.o_valid),     64'(e_valid));
      chk({tag, ".hit"},   64'(bus.o_hit),       64'(e_hit));
      chk({tag, ".way"},   64'(bus.o_hit_way),   64'(e_way));
      chk({tag, ".vec"},   64'(bus.o_hit_vec),   64'(e_vec));
      chk({tag, ".line"},  64'(bus.o_line),      64'(e_line));
      chk({tag, ".multi"}, 64'(bus.o_multi_hit), 64'(e_multi));
   endtask

   task automatic pack();
      bus.i_valid     = m_valid;
      bus.i_tag       = m_tag;
      bus.i_way_valid = m_vmask;
      for (int w = 0; w < 4; w++) begin
         bus.i_way_tags[w*TB +: TB]  = m_tags[w];
         bus.i_way_lines[w*LB +: LB] = m_lines[w];
      end
   endtask

   task automatic model_clear();
      e_valid = 0; e_hit = 0; e_multi = 0; e_way = 0; e_vec = 0; e_line = 0;
   endtask

   // Behavioural reference: list the matching ways, take the first one.
   task automatic model_edge();
      int hits[$];
      e_valid = m_valid;
      if (m_valid) begin
         for (int w = 0; w < 4; w++)
            if (m_vmask[w] && m_tags[w] == m_tag) hits.push_back(w);
         e_hit   = hits.size() > 0;
         e_vec   = 4'd0;
         foreach (hits[i]) e_vec[hits[i]] = 1'b1;
         e_way   = e_hit ? 2'(hits[0]) : 2'd0;
         e_line  = e_hit ? m_lines[hits[0]] : '0;
         e_multi = MULTI_EN && (hits.size() >= 2);
      end
   endtask

   // Called at a falling edge: drive, clock once, check half a cycle later.
   task automatic step(input string tag);
      pack();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk_all(tag);
   endtask

   task automatic randomize_inputs();
      m_valid = 1'($urandom);
      m_tag   = TB'($urandom);
      m_vmask = 4'($urandom);
      for (int w = 0; w < 4; w++) begin
         m_tags[w]  = TB'($urandom);
         m_lines[w] = $urandom;
      end
   endtask

   task automatic base_setup();
      m_tags[0] = 18'h00001; m_lines[0] = 32'h11111111;
      m_tags[1] = 18'h00002; m_lines[1] = 32'h22222222;
      m_tags[2] = 18'h00003; m_lines[2] = 32'h33333333;
      m_tags[3] = 18'h00004; m_lines[3] = 32'h44444444;
      m_vmask   = 4'b1111;
   endtask

   initial begin
      logic [TB-1:0] pool [4];

      // ---- reset held low with random inputs and a running clock
      rst = 1'b0;
      model_clear();
      for (int i = 0; i < 4; i++) begin
         randomize_inputs();
         pack();
         @(negedge clk);
         chk_all("reset_hold");
      end

      // ---- release with no lookup
      m_valid = 1'b0;
      pack();
      rst = 1'b1;
      step("after_release");

      // ---- single hit on way 2
      base_setup();
      m_tag = 18'h00003; m_valid = 1'b1;
      step("single_hit");

      // ---- matching tag in an invalid way never hits
      m_vmask = 4'b1011;
      step("invalid_way");

      // ---- ways 1 and 3 share a tag: way 1 wins
      base_setup();
      m_tags[1] = 18'h0ABCD; m_tags[3] = 18'h0ABCD; m_tag = 18'h0ABCD;
      step("multi_hit");

      // ---- back-to-back hits on way 0 then way 3, then idle hold
      base_setup();
      m_tag = 18'h00001; step("b2b_way0");
      m_tag = 18'h00004; step("b2b_way3");
      m_valid = 1'b0; m_tag = 18'h00002; step("hold_idle");
      step("hold_idle2");

      // ---- reset mid-lookup: outputs clear before the next edge
      m_valid = 1'b1; m_tag = 18'h00002; step("pre_reset_hit");
      m_tag = 18'h00003;
      pack();
      #2 rst = 1'b0;
      #1 model_clear();
      chk_all("async_reset");
      @(posedge clk);
      @(negedge clk);
      chk_all("reset_over_edge");
      rst = 1'b1;
      step("first_after_reset");

      // ---- randomized lookups from a small tag pool to force hits/multi-hits
      for (int i = 0; i < 4; i++) pool[i] = TB'($urandom);
      for (int n = 0; n < 150; n++) begin
         m_valid = ($urandom_range(0, 3) != 0);
         m_vmask = 4'($urandom);
         for (int w = 0; w < 4; w++) begin
            m_tags[w]  = pool[$urandom_range(0, 3)];
            m_lines[w] = $urandom;
         end
         m_tag = ($urandom_range(0, 7) == 0) ? TB'($urandom) : pool[$urandom_range(0, 3)];
         step("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
